// File: rtl/axil_master_bridge.sv
// Command/response to AXI-Lite master bridge.
// Handshakes: a transfer happens on any cycle where valid && ready are both
// high at the rising clock edge; a raised valid and its payload hold until then.
// One transaction is in flight at a time. An optional watchdog aborts stalled
// bus transactions with a SLVERR-coded response flagged by rsp_timeout.
module axil_master_bridge #(
    parameter int AXI_AWIDTH     = 12,
    parameter int AXI_DWIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    clk,
    input  logic                    rst_n,
    // command side
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [AXI_AWIDTH-1:0]   cmd_addr,
    input  logic [AXI_DWIDTH-1:0]   cmd_wdata,
    input  logic [AXI_DWIDTH/8-1:0] cmd_wstrb,
    // response side
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_write,
    output logic [AXI_DWIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    output logic                    rsp_timeout,
    // AXI-Lite master
    output logic [AXI_AWIDTH-1:0]   AWADDR,
    output logic [2:0]              AWPROT,
    output logic                    AWVALID,
    input  logic                    AWREADY,
    output logic [AXI_DWIDTH-1:0]   WDATA,
    output logic [AXI_DWIDTH/8-1:0] WSTRB,
    output logic                    WVALID,
    input  logic                    WREADY,
    input  logic                    BVALID,
    input  logic [1:0]              BRESP,
    output logic                    BREADY,
    output logic [AXI_AWIDTH-1:0]   ARADDR,
    output logic [2:0]              ARPROT,
    output logic                    ARVALID,
    input  logic                    ARREADY,
    input  logic [AXI_DWIDTH-1:0]   RDATA,
    input  logic [1:0]              RRESP,
    input  logic                    RVALID,
    output logic                    RREADY,
    // debug: current FSM state
    output logic [2:0]              state_dbg
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_DATA = 3'd4,
        RSP     = 3'd5
    } state_t;

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    // The abort fires in the cycle whose increment would reach the limit, so a
    // stalled request stays visible on the bus for exactly TIMEOUT_CYCLES cycles.
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic awvalid_d, wvalid_d, arvalid_d, bready_d, rready_d;
    logic [AXI_AWIDTH-1:0] awaddr_d, araddr_d;
    logic [AXI_DWIDTH-1:0] wdata_d, rsp_rdata_d;
    logic [AXI_DWIDTH/8-1:0] wstrb_d;
    logic rsp_valid_d, rsp_write_d, rsp_timeout_d;
    logic [1:0] rsp_resp_d;
    logic busy, done, to_hit;

    assign cmd_ready = (state_q == IDLE);
    assign AWPROT    = 3'b000;
    assign ARPROT    = 3'b000;
    assign state_dbg = state_q;

    // Next state, next registered outputs and watchdog counter.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        awvalid_d     = AWVALID;
        wvalid_d      = WVALID;
        arvalid_d     = ARVALID;
        bready_d      = BREADY;
        rready_d      = RREADY;
        awaddr_d      = AWADDR;
        araddr_d      = ARADDR;
        wdata_d       = WDATA;
        wstrb_d       = WSTRB;
        rsp_valid_d   = rsp_valid;
        rsp_write_d   = rsp_write;
        rsp_rdata_d   = rsp_rdata;
        rsp_resp_d    = rsp_resp;
        rsp_timeout_d = rsp_timeout;
        done          = 1'b0;
        busy          = (state_q == WR_REQ) || (state_q == WR_RESP) ||
                        (state_q == RD_REQ) || (state_q == RD_DATA);
        to_hit        = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);

        if (busy && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    cnt_d       = '0;
                    rsp_write_d = cmd_write;
                    if (cmd_write) begin
                        awaddr_d  = cmd_addr;
                        wdata_d   = cmd_wdata;
                        wstrb_d   = cmd_wstrb;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WR_REQ;
                    end else begin
                        araddr_d  = cmd_addr;
                        arvalid_d = 1'b1;
                        state_d   = RD_REQ;
                    end
                end
            end
            WR_REQ: begin
                // AW and W complete independently; each valid drops after its own handshake.
                awvalid_d = AWVALID && !AWREADY;
                wvalid_d  = WVALID && !WREADY;
                if (!awvalid_d && !wvalid_d) begin
                    done     = 1'b1;
                    bready_d = 1'b1;
                    state_d  = WR_RESP;
                end
            end
            WR_RESP: begin
                if (BVALID && BREADY) begin
                    done          = 1'b1;
                    bready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_resp_d    = BRESP;
                    rsp_rdata_d   = '0;
                    rsp_timeout_d = 1'b0;
                    state_d       = RSP;
                end
            end
            RD_REQ: begin
                if (ARVALID && ARREADY) begin
                    done      = 1'b1;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_DATA;
                end
            end
            RD_DATA: begin
                if (RVALID && RREADY) begin
                    done          = 1'b1;
                    rready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_resp_d    = RRESP;
                    rsp_rdata_d   = RDATA;
                    rsp_timeout_d = 1'b0;
                    state_d       = RSP;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Watchdog abort; a completion in the same cycle wins.
        if (busy && !done && to_hit) begin
            awvalid_d     = 1'b0;
            wvalid_d      = 1'b0;
            arvalid_d     = 1'b0;
            bready_d      = 1'b0;
            rready_d      = 1'b0;
            rsp_valid_d   = 1'b1;
            rsp_resp_d    = 2'b10;
            rsp_rdata_d   = '0;
            rsp_timeout_d = 1'b1;
            state_d       = RSP;
        end
    end

    // State, counter and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            AWVALID     <= 1'b0;
            WVALID      <= 1'b0;
            ARVALID     <= 1'b0;
            BREADY      <= 1'b0;
            RREADY      <= 1'b0;
            AWADDR      <= '0;
            WDATA       <= '0;
            WSTRB       <= '0;
            ARADDR      <= '0;
            rsp_valid   <= 1'b0;
            rsp_write   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_resp    <= 2'b00;
            rsp_timeout <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            AWVALID     <= awvalid_d;
            WVALID      <= wvalid_d;
            ARVALID     <= arvalid_d;
            BREADY      <= bready_d;
            RREADY      <= rready_d;
            AWADDR      <= awaddr_d;
            WDATA       <= wdata_d;
            WSTRB       <= wstrb_d;
            ARADDR      <= araddr_d;
            rsp_valid   <= rsp_valid_d;
            rsp_write   <= rsp_write_d;
            rsp_rdata   <= rsp_rdata_d;
            rsp_resp    <= rsp_resp_d;
            rsp_timeout <= rsp_timeout_d;
        end
    end

endmodule

// File: tb/tb_axil_master_bridge.sv
// Bench for axil_master_bridge: scripted AXI-Lite slave, response scoreboard.
module tb_axil_master_bridge;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [3:0]    cmd_wstrb;
    logic          rsp_valid, rsp_ready, rsp_write, rsp_timeout;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic [AW-1:0] AWADDR, ARADDR;
    logic [2:0]    AWPROT, ARPROT, state_dbg;
    logic          AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic          ARVALID, ARREADY, RVALID, RREADY;
    logic [DW-1:0] WDATA, RDATA;
    logic [3:0]    WSTRB;
    logic [1:0]    BRESP, RRESP;

    // expected response: {write, timeout, resp, rdata}
    logic [35:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    axil_master_bridge #(.AXI_AWIDTH(AW), .AXI_DWIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BVALID(BVALID), .BRESP(BRESP), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .state_dbg(state_dbg)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got hang expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic slave_idle();
        AWREADY = 1'b0;
        WREADY  = 1'b0;
        ARREADY = 1'b0;
        BVALID  = 1'b0;
        BRESP   = 2'b11;
        RVALID  = 1'b0;
        RRESP   = 2'b11;
        RDATA   = 32'hBAD0_BAD0;
    endtask

    // Issue one command, act as the slave with the given delays, then take the
    // response after holding rsp_ready low for `hold` cycles.
    task automatic run_txn(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input logic [3:0] strb, input int aw_dly, input int w_dly,
                           input int ar_dly, input int rsp_dly, input logic [1:0] resp,
                           input logic [DW-1:0] rdata, input logic exp_to, input int hold);
        int aw_hs = 0, w_hs = 0, ar_hs = 0, b_hs = 0, r_hs = 0;
        int aw_cyc = 0, w_cyc = 0, ar_cyc = 0, b_cnt = 0, r_cnt = 0;
        bit got = 1'b0;
        logic [35:0] e;
        logic [35:0] obs;
        @(negedge clk);
        check("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = data;
        cmd_wstrb = strb;
        if (exp_to)  e = {wr, 1'b1, 2'b10, 32'h0};
        else if (wr) e = {1'b1, 1'b0, resp, 32'h0};
        else         e = {1'b0, 1'b0, resp, rdata};
        exp_q.push_back(e);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            cmd_wdata = 32'h0;
            cmd_addr  = '0;
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
            if (AWVALID) begin
                aw_cyc++;
                check("awaddr_stable", AWADDR, addr);
            end
            AWREADY = AWVALID && (c >= aw_dly);
            if (AWVALID && AWREADY) aw_hs++;
            if (WVALID) begin
                w_cyc++;
                check("wdata_stable", {WSTRB, WDATA}, {strb, data});
            end
            WREADY = WVALID && (c >= w_dly);
            if (WVALID && WREADY) w_hs++;
            if (BREADY) begin
                b_cnt++;
                BVALID = (b_cnt > rsp_dly);
                BRESP  = resp;
            end else begin
                BVALID = 1'b0;
            end
            if (BVALID && BREADY) b_hs++;
            if (ARVALID) begin
                ar_cyc++;
                check("araddr_stable", ARADDR, addr);
            end
            ARREADY = ARVALID && (c >= ar_dly);
            if (ARVALID && ARREADY) ar_hs++;
            if (RREADY) begin
                r_cnt++;
                RVALID = (r_cnt > rsp_dly);
                RRESP  = resp;
                RDATA  = rdata;
            end else begin
                RVALID = 1'b0;
            end
            if (RVALID && RREADY) r_hs++;
        end
        slave_idle();
        check("rsp_arrived", got, 1);
        if (exp_to) begin
            check("to_valid_cycles", wr ? aw_cyc : ar_cyc, TO);
            check("to_outputs_low", {AWVALID, WVALID, ARVALID, BREADY, RREADY}, 0);
        end else if (wr) begin
            check("aw_handshakes", aw_hs, 1);
            check("w_handshakes", w_hs, 1);
            check("b_handshakes", b_hs, 1);
            check("aw_valid_cycles", aw_cyc, aw_dly + 1);
            check("w_valid_cycles", w_cyc, w_dly + 1);
        end else begin
            check("ar_handshakes", ar_hs, 1);
            check("r_handshakes", r_hs, 1);
            check("ar_valid_cycles", ar_cyc, ar_dly + 1);
        end
        for (int i = 0; i < hold; i++) begin
            rsp_ready = 1'b0;
            check("hold_rsp_valid", rsp_valid, 1);
            check("hold_cmd_ready", cmd_ready, 0);
            check("hold_fields", {rsp_write, rsp_timeout, rsp_resp, rsp_rdata}, exp_q[0]);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        check("rsp_valid", rsp_valid, 1);
        obs = {rsp_write, rsp_timeout, rsp_resp, rsp_rdata};
        e = exp_q.pop_front();
        check("rsp_fields", obs, e);
        @(negedge clk);
        rsp_ready = 1'b0;
        check("cmd_ready_after_rsp", cmd_ready, 1);
        check("rsp_valid_after_rsp", rsp_valid, 0);
    endtask

    // Reset while a write waits for its B response; the write is abandoned.
    task automatic reset_in_wr_resp();
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 12'h044;
        cmd_wdata = 32'hCAFE_F00D;
        cmd_wstrb = 4'hF;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            if (BREADY) break;
            AWREADY = AWVALID;
            WREADY  = WVALID;
        end
        slave_idle();
        check("reached_wr_resp", state_dbg, 3'd2);
        #1 rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {AWVALID, WVALID, ARVALID, BREADY, RREADY, rsp_valid}, 0);
        @(negedge clk);
        check("reset_held_outputs", {AWVALID, WVALID, ARVALID, BREADY, RREADY, rsp_valid}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_cmd_ready", cmd_ready, 1);
        check("post_reset_state", state_dbg, 3'd0);
        check("post_reset_no_rsp", rsp_valid, 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_wstrb = '0;
        rsp_ready = 1'b0;
        slave_idle();
        repeat (3) @(negedge clk);
        check("reset_cmd_ready", cmd_ready, 1);
        check("reset_valids", {AWVALID, WVALID, ARVALID, BREADY, RREADY, rsp_valid}, 0);
        check("reset_payloads", {AWADDR, WDATA, WSTRB, ARADDR}, 0);
        check("reset_rsp", {rsp_resp, rsp_rdata, rsp_timeout}, 0);
        check("prot_const", {AWPROT, ARPROT}, 0);
        rst_n = 1'b1;

        // single-cycle AW/W, B two cycles later
        run_txn(1'b1, 12'h010, 32'hDEADBEEF, 4'hF, 0, 0, 0, 2, 2'b00, 32'h0, 1'b0, 0);
        // WREADY three cycles after AWREADY
        run_txn(1'b1, 12'h010, 32'hDEADBEEF, 4'hF, 0, 3, 0, 1, 2'b00, 32'h0, 1'b0, 0);
        // AWREADY late, W first
        run_txn(1'b1, 12'h0F8, 32'h0102_0304, 4'h5, 2, 0, 0, 0, 2'b01, 32'h0, 1'b0, 0);
        // read with ARREADY after two cycles and SLVERR
        run_txn(1'b0, 12'h020, 32'h0, 4'h0, 0, 0, 2, 0, 2'b10, 32'h12345678, 1'b0, 0);
        // read that never gets ARREADY
        run_txn(1'b0, 12'h030, 32'h0, 4'h0, 0, 0, 100, 0, 2'b00, 32'h0, 1'b1, 0);
        // write that never gets AWREADY/WREADY
        run_txn(1'b1, 12'h034, 32'h5555AAAA, 4'hF, 100, 100, 0, 0, 2'b00, 32'h0, 1'b1, 0);
        // response back-pressure for five cycles
        run_txn(1'b0, 12'h040, 32'h0, 4'h0, 0, 0, 1, 1, 2'b00, 32'hA5A5_5A5A, 1'b0, 5);
        // random mix within the watchdog window
        for (int k = 0; k < 8; k++) begin
            logic wr;
            logic [AW-1:0] a;
            logic [DW-1:0] d;
            wr = 1'($urandom_range(0, 1));
            a  = AW'($urandom_range(0, 4095));
            d  = $urandom;
            run_txn(wr, a, d, 4'($urandom_range(0, 15)), $urandom_range(0, 2),
                    $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 2),
                    2'($urandom_range(0, 3)), $urandom, 1'b0, $urandom_range(0, 2));
        end
        reset_in_wr_resp();
        run_txn(1'b1, 12'h048, 32'h7777_8888, 4'h3, 0, 1, 0, 1, 2'b00, 32'h0, 1'b0, 1);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/axil_master_bridge.md
AXIL_MASTER_BRIDGE -- requirements
Module: axil_master_bridge

Interface
REQ-001 SHALL have parameter AXI_AWIDTH, default 12, AXI-Lite address width.
REQ-002 SHALL have parameter AXI_DWIDTH, default 32, AXI-Lite data width (multiple of 8).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 256, abort limit in cycles; 0 disables timeout.
REQ-004 SHALL have one clock and an asynchronous active-low reset: clk  input  1  clock; rst_n  input  1  async active-low reset.
REQ-005 Command ports SHALL be: cmd_valid  in  1; cmd_ready  out  1; cmd_write  in  1  (1=write); cmd_addr  in  AXI_AWIDTH; cmd_wdata  in  AXI_DWIDTH; cmd_wstrb  in  AXI_DWIDTH/8.
REQ-006 Response ports SHALL be: rsp_valid  out  1; rsp_ready  in  1; rsp_write  out  1; rsp_rdata  out  AXI_DWIDTH; rsp_resp  out  2; rsp_timeout  out  1.
REQ-007 AXI-Lite master ports SHALL be: AWADDR/AWPROT/AWVALID out, AWREADY in; WDATA/WSTRB/WVALID out, WREADY in; BVALID/BRESP in, BREADY out; ARADDR/ARPROT/ARVALID out, ARREADY in; RDATA/RRESP/RVALID in, RREADY out; widths per AXI_AWIDTH/AXI_DWIDTH, PROT 3, RESP 2.

Function
REQ-008 SHALL implement FSM states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.
REQ-009 cmd_ready SHALL be 1 only in IDLE; command accepted on cmd_valid&cmd_ready; one outstanding transaction max.
REQ-010 On accepted write: register addr/wdata/wstrb, assert AWVALID and WVALID next cycle, enter WR_REQ.
REQ-011 In WR_REQ, AWVALID SHALL drop the cycle after AWVALID&AWREADY, WVALID likewise after WVALID&WREADY, independently; both done (same or different cycles) -> WR_RESP.
REQ-012 In WR_RESP, BREADY SHALL be 1; on BVALID capture BRESP into rsp_resp, rsp_rdata=0, -> RSP.
REQ-013 On accepted read: register addr, assert ARVALID next cycle, enter RD_REQ; on ARVALID&ARREADY drop ARVALID -> RD_DATA.
REQ-014 In RD_DATA, RREADY SHALL be 1; on RVALID capture RDATA/RRESP -> RSP.
REQ-015 BREADY/RREADY SHALL be 0 outside WR_RESP/RD_DATA; early BVALID/RVALID in other states SHALL be ignored (held by slave).
REQ-016 Once asserted, AWVALID/WVALID/ARVALID and their payloads SHALL remain stable until handshake, except on timeout.
REQ-017 AWPROT and ARPROT SHALL be constant 3'b000.
REQ-018 In RSP, rsp_valid=1 with rsp_write/rsp_rdata/rsp_resp/rsp_timeout stable until rsp_ready; then -> IDLE; back-to-back: new cmd accepted the cycle after rsp handshake.
REQ-019 Timeout counter SHALL clear on command acceptance, increment each cycle in WR_REQ/WR_RESP/RD_REQ/RD_DATA, saturating.
REQ-020 When counter reaches TIMEOUT_CYCLES (non-zero), SHALL deassert all VALID/READY outputs, set rsp_resp=2'b10, rsp_timeout=1, rsp_rdata=0, -> RSP; completion in the same cycle SHALL take priority over timeout.
REQ-021 All outputs except cmd_ready SHALL be driven from flops.

Reset
REQ-022 On rst_n low, asynchronously: state=IDLE, all AXI VALID/READY=0, AWADDR/WDATA/WSTRB/ARADDR=0, rsp_valid=0, rsp_resp=0, rsp_rdata=0, rsp_timeout=0, counter=0.
REQ-023 Reset mid-transaction SHALL abandon it with no response; first cycle after release SHALL be IDLE with cmd_ready=1.

Verification
REQ-024 Write addr=0x010 data=0xDEADBEEF strb=0xF, AWREADY=WREADY=1, BVALID 2 cycles later BRESP=0 -> AW/W one-cycle each, rsp_valid rsp_write=1 rsp_resp=0.
REQ-025 Write with WREADY 3 cycles after AWREADY -> AWVALID drops after its handshake, WVALID held stable with 0xDEADBEEF until WREADY, one B handshake.
REQ-026 Read addr=0x020, ARREADY after 2 cycles, RDATA=0x12345678 RRESP=2'b10 -> rsp_rdata=0x12345678 rsp_resp=2'b10 rsp_write=0.
REQ-027 TIMEOUT_CYCLES=8, read with ARREADY never asserted -> after 8 cycles ARVALID=0, rsp_resp=2'b10, rsp_timeout=1.
REQ-028 rsp_ready held low 5 cycles -> response fields stable, cmd_ready=0 throughout; rsp_ready=1 -> cmd_ready=1 next cycle.
REQ-029 rst_n pulsed low during WR_RESP -> all VALID/READY=0 immediately, no rsp_valid, next write completes normally.
